// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder scan controller.
//   N_CH         : number of decoder channels (one per decoder output)
//   CH_W         : width of a channel index
//   scan_state_e : controller states
package decoder_scan_pkg;

    localparam int unsigned N_CH = 16;
    localparam int unsigned CH_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DWELL,
        ST_GAP
    } scan_state_e;

endpackage

// File: rtl/next_ch_find.sv
// Combinational search for the next channel to scan.
//   mask  in  N_CH  channels eligible for scanning
//   cur   in  CH_W  channel currently (or last) scanned
//   first in  1     1 = ignore cur and return the lowest set bit overall
//   found out 1     a qualifying channel exists
//   idx   out CH_W  lowest set index above cur (or lowest overall when first=1)
module next_ch_find
    import decoder_scan_pkg::*;
(
    input  logic [N_CH-1:0] mask,
    input  logic [CH_W-1:0] cur,
    input  logic            first,
    output logic            found,
    output logic [CH_W-1:0] idx
);

    // Scan from the top down so the lowest qualifying index is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (mask[N_CH-1-i] && (first || ((N_CH-1-i) > 32'(cur)))) begin
                found = 1'b1;
                idx   = CH_W'(N_CH-1-i);
            end
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller for an external 4-to-16 decoder: steps through the set bits
// of a channel mask, holding the decoder enabled for a programmable dwell on
// each channel and inserting a one-cycle blanking gap between channels.
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   begin scanning (sampled only when idle)
//   stop       in   end scanning after the current channel
//   mode       in   0 = continuous sweeps, 1 = single sweep
//   dwell      in   enable-high cycles per channel (0 treated as 1)
//   ch_mask    in   channels included in a sweep
//   a          out  decoder select
//   enable     out  decoder enable
//   busy       out  high whenever not idle
//   sweep_done out  one-cycle pulse at the end of each full sweep
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [N_CH-1:0]    ch_mask,
    output logic [CH_W-1:0]    a,
    output logic               enable,
    output logic               busy,
    output logic               sweep_done
);

    scan_state_e        state_q, state_d;
    logic [CH_W-1:0]    a_q, a_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               sweep_done_q, sweep_done_d;
    logic               stop_pend_q, stop_pend_d;
    logic [N_CH-1:0]    mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               mode_q, mode_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic               first_found, next_found, stop_eff;
    logic [CH_W-1:0]    first_idx, next_idx;

    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        return (d == '0) ? '0 : d - DWELL_W'(1);
    endfunction

    // Lowest channel of the live input mask: used at every latch point.
    next_ch_find u_first (
        .mask  (ch_mask),
        .cur   ('0),
        .first (1'b1),
        .found (first_found),
        .idx   (first_idx)
    );

    // Next channel within the latched sweep.
    next_ch_find u_next (
        .mask  (mask_q),
        .cur   (a_q),
        .first (1'b0),
        .found (next_found),
        .idx   (next_idx)
    );

    // A stop arriving in the gap cycle itself still ends the scan at this channel.
    assign stop_eff = stop_pend_q | stop;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        enable_d     = 1'b0;
        sweep_done_d = 1'b0;
        stop_pend_d  = stop_pend_q;
        mask_d       = mask_q;
        dwell_d      = dwell_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop && first_found) begin
                    mask_d   = ch_mask;
                    dwell_d  = dwell;
                    mode_d   = mode;
                    cnt_d    = dwell_load(dwell);
                    a_d      = first_idx;
                    enable_d = 1'b1;
                    state_d  = ST_DWELL;
                end
            end

            ST_DWELL: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d    = cnt_q - DWELL_W'(1);
                    enable_d = 1'b1;
                end
            end

            ST_GAP: begin
                if (next_found && !stop_eff) begin
                    a_d      = next_idx;
                    cnt_d    = dwell_load(dwell_q);
                    enable_d = 1'b1;
                    state_d  = ST_DWELL;
                end else begin
                    stop_pend_d = 1'b0;
                    state_d     = ST_IDLE;
                    if (!next_found) begin
                        sweep_done_d = 1'b1;
                        // Continuous mode restarts from a freshly latched mask.
                        if (!mode_q && !stop_eff && first_found) begin
                            mask_d   = ch_mask;
                            dwell_d  = dwell;
                            cnt_d    = dwell_load(dwell);
                            a_d      = first_idx;
                            enable_d = 1'b1;
                            state_d  = ST_DWELL;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
            stop_pend_q  <= 1'b0;
            mask_q       <= '0;
            dwell_q      <= '0;
            mode_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
            stop_pend_q  <= stop_pend_d;
            mask_q       <= mask_d;
            dwell_q      <= dwell_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
        end
    end

    assign a          = a_q;
    assign enable     = enable_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
module tb_decoder_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] dwell;
    logic [15:0] ch_mask;
    logic [3:0]  a;
    logic        enable;
    logic        busy;
    logic        sweep_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    decoder_scan_ctrl #(.DWELL_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .dwell      (dwell),
        .ch_mask    (ch_mask),
        .a          (a),
        .enable     (enable),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all outputs for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic en, input logic [3:0] ax,
                       input logic b, input logic sd);
        chk({tag, ".enable"}, 16'(enable), 16'(en));
        chk({tag, ".a"}, 16'(a), 16'(ax));
        chk({tag, ".busy"}, 16'(busy), 16'(b));
        chk({tag, ".sweep_done"}, 16'(sweep_done), 16'(sd));
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 1'b0;
        dwell   = '0;
        ch_mask = '0;
        #1;
        cyc("reset", 1'b0, 4'd0, 1'b0, 1'b0);
        cyc("reset_hold", 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single channel, dwell 3, single sweep.
        ch_mask = 16'h0001; dwell = 16'd3; mode = 1'b1;
        pulse_start();
        cyc("t1.d0", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t1.d1", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t1.d2", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t1.gap", 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("t1.done", 1'b0, 4'd0, 1'b0, 1'b1);
        cyc("t1.idle", 1'b0, 4'd0, 1'b0, 1'b0);

        // Continuous sweep over 0,5,10,15.
        ch_mask = 16'h8421; dwell = 16'd2; mode = 1'b0;
        pulse_start();
        for (int s = 0; s < 2; s++) begin
            cyc("t2.c0a", 1'b1, 4'd0, 1'b1, (s == 1) ? 1'b1 : 1'b0);
            cyc("t2.c0b", 1'b1, 4'd0, 1'b1, 1'b0);
            cyc("t2.c0g", 1'b0, 4'd0, 1'b1, 1'b0);
            cyc("t2.c5a", 1'b1, 4'd5, 1'b1, 1'b0);
            cyc("t2.c5b", 1'b1, 4'd5, 1'b1, 1'b0);
            cyc("t2.c5g", 1'b0, 4'd5, 1'b1, 1'b0);
            cyc("t2.c10a", 1'b1, 4'd10, 1'b1, 1'b0);
            cyc("t2.c10b", 1'b1, 4'd10, 1'b1, 1'b0);
            cyc("t2.c10g", 1'b0, 4'd10, 1'b1, 1'b0);
            cyc("t2.c15a", 1'b1, 4'd15, 1'b1, 1'b0);
            cyc("t2.c15b", 1'b1, 4'd15, 1'b1, 1'b0);
            cyc("t2.c15g", 1'b0, 4'd15, 1'b1, 1'b0);
        end
        stop = 1'b1;
        cyc("t2.stop_a", 1'b1, 4'd0, 1'b1, 1'b1);
        stop = 1'b0;
        cyc("t2.stop_b", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t2.stop_g", 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("t2.stop_idle", 1'b0, 4'd0, 1'b0, 1'b0);

        // Dwell 0 treated as 1: four busy cycles.
        ch_mask = 16'h0003; dwell = 16'd0; mode = 1'b1;
        pulse_start();
        cyc("t3.c0", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t3.g0", 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("t3.c1", 1'b1, 4'd1, 1'b1, 1'b0);
        cyc("t3.g1", 1'b0, 4'd1, 1'b1, 1'b0);
        cyc("t3.done", 1'b0, 4'd1, 1'b0, 1'b1);

        // Stop during channel 5 dwell, continuous mode.
        ch_mask = 16'h00F0; dwell = 16'd2; mode = 1'b0;
        pulse_start();
        cyc("t4.c4a", 1'b1, 4'd4, 1'b1, 1'b0);
        cyc("t4.c4b", 1'b1, 4'd4, 1'b1, 1'b0);
        cyc("t4.g4", 1'b0, 4'd4, 1'b1, 1'b0);
        stop = 1'b1;
        cyc("t4.c5a", 1'b1, 4'd5, 1'b1, 1'b0);
        stop = 1'b0;
        cyc("t4.c5b", 1'b1, 4'd5, 1'b1, 1'b0);
        cyc("t4.g5", 1'b0, 4'd5, 1'b1, 1'b0);
        cyc("t4.idle0", 1'b0, 4'd5, 1'b0, 1'b0);
        cyc("t4.idle1", 1'b0, 4'd5, 1'b0, 1'b0);

        // Ignored starts: empty mask, then start with stop.
        ch_mask = 16'h0000; mode = 1'b1;
        pulse_start();
        cyc("t5.nomask", 1'b0, 4'd5, 1'b0, 1'b0);
        ch_mask = 16'h000F; stop = 1'b1;
        pulse_start();
        stop = 1'b0;
        cyc("t5.startstop", 1'b0, 4'd5, 1'b0, 1'b0);

        // Mask/dwell change and start while busy have no effect mid-sweep.
        ch_mask = 16'h0006; dwell = 16'd1; mode = 1'b1;
        pulse_start();
        ch_mask = 16'h0001; dwell = 16'd5; start = 1'b1;
        cyc("t6.c1", 1'b1, 4'd1, 1'b1, 1'b0);
        start = 1'b0;
        cyc("t6.g1", 1'b0, 4'd1, 1'b1, 1'b0);
        cyc("t6.c2", 1'b1, 4'd2, 1'b1, 1'b0);
        cyc("t6.g2", 1'b0, 4'd2, 1'b1, 1'b0);
        cyc("t6.done", 1'b0, 4'd2, 1'b0, 1'b1);
        dwell = 16'd1;
        pulse_start();
        cyc("t6.new_c0", 1'b1, 4'd0, 1'b1, 1'b0);
        cyc("t6.new_g0", 1'b0, 4'd0, 1'b1, 1'b0);
        cyc("t6.new_done", 1'b0, 4'd0, 1'b0, 1'b1);

        // Asynchronous reset during channel 3 dwell.
        ch_mask = 16'h0008; dwell = 16'd4; mode = 1'b1;
        pulse_start();
        chk("t7.pre_en", 16'(enable), 16'd1);
        chk("t7.pre_a", 16'(a), 16'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7.async_en", 16'(enable), 16'd0);
        chk("t7.async_a", 16'(a), 16'd0);
        chk("t7.async_busy", 16'(busy), 16'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        cyc("t7.post_idle", 1'b0, 4'd0, 1'b0, 1'b0);
        ch_mask = 16'h0108; dwell = 16'd1;
        pulse_start();
        cyc("t7.restart_c3", 1'b1, 4'd3, 1'b1, 1'b0);
        cyc("t7.restart_g3", 1'b0, 4'd3, 1'b1, 1'b0);
        cyc("t7.restart_c8", 1'b1, 4'd8, 1'b1, 1'b0);
        cyc("t7.restart_g8", 1'b0, 4'd8, 1'b1, 1'b0);
        cyc("t7.restart_done", 1'b0, 4'd8, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
